// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped reload timer: register window
// layout, TCON bit positions and the address-to-word-offset helper.
`timescale 1ns/1ps
package timer_pkg;

  // Default base of the three-word register window.
  localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h4000_0000;

  // Word offsets within the window.
  localparam logic [29:0] TH_OFS   = 30'd0;
  localparam logic [29:0] TL_OFS   = 30'd1;
  localparam logic [29:0] TCON_OFS = 30'd2;

  // TCON bit positions.
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  // Word distance of a bus address from the window base; byte lanes are ignored.
  function automatic logic [29:0] word_offset(input logic [29:0] addr_word,
                                              input logic [29:0] base_word);
    return addr_word - base_word;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock by PRESCALE while enabled and emits a one-cycle tick on
// each wrap. The count is forced back to 0 whenever the timer is stopped, so
// every re-enable starts a full prescale period.
`timescale 1ns/1ps
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_pass
      // Every enabled cycle is a tick; no counter state is needed.
      logic unused_inputs;
      assign unused_inputs = clk ^ reset;
      assign tick = en;
    end else begin : g_cnt
      localparam int CW = $clog2(PRESCALE);
      localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

      logic [CW-1:0] count_reg;

      // Count 0..PRESCALE-1 while enabled, hold at 0 while stopped.
      always_ff @(posedge clk) begin
        if (!reset) begin
          count_reg <= '0;
        end else if (!en || count_reg == LAST) begin
          count_reg <= '0;
        end else begin
          count_reg <= count_reg + CW'(1);
        end
      end

      assign tick = en && (count_reg == LAST);
    end
  endgenerate

endmodule

// File: rtl/timer_periph.sv
// Memory-mapped 32-bit reload timer: TH (reload), TL (counter) and TCON
// (EN/IE/IS). TL counts prescaled ticks, reloads from TH after 0xFFFF_FFFF
// and latches a sticky interrupt status when IE is set.
`timescale 1ns/1ps
module timer_periph
  import timer_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DEFAULT_ADDR_BASE,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Interrupt
);

  logic [31:0] th_reg;
  logic [31:0] tl_reg;
  logic        en_reg;
  logic        ie_reg;
  logic        is_reg;

  logic [29:0] ofs;
  logic        sel_th, sel_tl, sel_tcon;
  logic        wr_th, wr_tl, wr_tcon;
  logic        tick;
  logic        overflow;
  logic        set_is;

  // Byte-lane bits take no part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Addr[1:0];

  assign ofs      = word_offset(Addr[31:2], ADDR_BASE[31:2]);
  assign sel_th   = (ofs == TH_OFS);
  assign sel_tl   = (ofs == TL_OFS);
  assign sel_tcon = (ofs == TCON_OFS);

  assign wr_th   = MemWr && sel_th;
  assign wr_tl   = MemWr && sel_tl;
  assign wr_tcon = MemWr && sel_tcon;

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en_reg),
    .tick (tick)
  );

  // Overflow is the tick that finds TL saturated; it only raises IS if the
  // interrupt was enabled before any same-cycle TCON write.
  assign overflow = tick && (tl_reg == 32'hFFFF_FFFF);
  assign set_is   = overflow && ie_reg;

  // Register updates: bus writes take priority over counting, but a
  // coincident overflow still latches IS so no interrupt is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      th_reg <= '0;
      tl_reg <= '0;
      en_reg <= 1'b0;
      ie_reg <= 1'b0;
      is_reg <= 1'b0;
    end else begin
      if (wr_th) begin
        th_reg <= WriteData;
      end

      if (wr_tl) begin
        tl_reg <= WriteData;
      end else if (tick) begin
        tl_reg <= overflow ? th_reg : tl_reg + 32'd1;
      end

      if (wr_tcon) begin
        en_reg <= WriteData[TCON_EN];
        ie_reg <= WriteData[TCON_IE];
        is_reg <= WriteData[TCON_IS] | set_is;
      end else if (set_is) begin
        is_reg <= 1'b1;
      end
    end
  end

  // Combinational read mux; unmapped offsets and idle bus read as zero.
  always_comb begin
    ReadData = '0;
    if (MemRd) begin
      if (sel_th) begin
        ReadData = th_reg;
      end else if (sel_tl) begin
        ReadData = tl_reg;
      end else if (sel_tcon) begin
        ReadData = {29'd0, is_reg, ie_reg, en_reg};
      end
    end
  end

  assign Interrupt = is_reg & ie_reg;

endmodule

// File: tb/tb_timer_periph.sv
// Self-checking bench for timer_periph: one instance with PRESCALE=1 for the
// reload/interrupt sequences, one with PRESCALE=4 for decode and prescaling.
`timescale 1ns/1ps
module tb_timer_periph;
  import timer_pkg::*;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mem_rd;
  logic [1:0]  mem_wr;
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [1:0]  irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_periph #(.ADDR_BASE(B), .PRESCALE(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .MemRd    (mem_rd[0]),
    .MemWr    (mem_wr[0]),
    .Addr     (addr[0]),
    .WriteData(wdata[0]),
    .ReadData (rdata[0]),
    .Interrupt(irq[0])
  );

  timer_periph #(.ADDR_BASE(B), .PRESCALE(4)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .MemRd    (mem_rd[1]),
    .MemWr    (mem_wr[1]),
    .Addr     (addr[1]),
    .WriteData(wdata[1]),
    .ReadData (rdata[1]),
    .Interrupt(irq[1])
  );

  typedef struct {
    string       name;
    int          s;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        chk;
    logic [31:0] er;
    logic        ei;
  } vec_t;

  vec_t vt[14];

  task automatic idle();
    mem_rd = '0;
    mem_wr = '0;
    for (int s = 0; s < 2; s++) begin
      addr[s]  = '0;
      wdata[s] = '0;
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic check_out();
    exp_t        e;
    logic [31:0] got_rd;
    logic        got_irq;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
      return;
    end
    e       = sb.pop_front();
    got_rd  = rdata[e.s];
    got_irq = irq[e.s];
    if (e.chk) begin
      checks++;
      if (got_rd !== e.exp_rd) begin
        errors++;
        $display("FAIL %s dut%0d ReadData got %h want %h", e.name, e.s, got_rd, e.exp_rd);
      end
    end
    checks++;
    if (got_irq !== e.exp_irq) begin
      errors++;
      $display("FAIL %s dut%0d Interrupt got %b want %b", e.name, e.s, got_irq, e.exp_irq);
    end
    $display("txn %-12s dut%0d rd=%h irq=%b", e.name, e.s, got_rd, got_irq);
  endtask

  // One bus cycle: drive just after the edge, check at the falling edge.
  task automatic cycle(input int s, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic chk, input logic [31:0] er, input logic ei,
                       input string name);
    exp_t e;
    idle();
    mem_rd[s] = r;
    mem_wr[s] = w;
    addr[s]   = a;
    wdata[s]  = d;
    e.name = name; e.s = s; e.chk = chk; e.exp_rd = er; e.exp_irq = ei;
    sb.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int s, input logic [31:0] a, input logic [31:0] d,
                    input logic ei, input string name);
    cycle(s, 1'b0, 1'b1, a, d, 1'b0, 32'd0, ei, name);
  endtask

  task automatic rd(input int s, input logic [31:0] a, input logic [31:0] e,
                    input logic ei, input string name);
    cycle(s, 1'b1, 1'b0, a, 32'd0, 1'b1, e, ei, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_tl [9];
    exp_tl = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};

    // Decode / readback vectors on the stopped PRESCALE=4 instance.
    vt[0]  = '{1'b0, 1'b1, B + 32'd0,  32'hAAAA_0001, 1'b0, 32'h0,         1'b0};
    vt[1]  = '{1'b0, 1'b1, B + 32'd4,  32'h5555_0002, 1'b0, 32'h0,         1'b0};
    vt[2]  = '{1'b0, 1'b1, B + 32'd8,  32'h0000_0002, 1'b0, 32'h0,         1'b0};
    vt[3]  = '{1'b0, 1'b1, B + 32'd12, 32'h0000_1234, 1'b0, 32'h0,         1'b0};
    vt[4]  = '{1'b0, 1'b1, B + 32'd16, 32'h0000_1234, 1'b0, 32'h0,         1'b0};
    vt[5]  = '{1'b1, 1'b0, B + 32'd12, 32'h0,         1'b1, 32'h0,         1'b0};
    vt[6]  = '{1'b1, 1'b0, B + 32'd16, 32'h0,         1'b1, 32'h0,         1'b0};
    vt[7]  = '{1'b1, 1'b0, B + 32'd0,  32'h0,         1'b1, 32'hAAAA_0001, 1'b0};
    vt[8]  = '{1'b1, 1'b0, B + 32'd7,  32'h0,         1'b1, 32'h5555_0002, 1'b0};
    vt[9]  = '{1'b1, 1'b0, B + 32'd10, 32'h0,         1'b1, 32'h0000_0002, 1'b0};
    vt[10] = '{1'b1, 1'b0, B - 32'd4,  32'h0,         1'b1, 32'h0,         1'b0};
    vt[11] = '{1'b0, 1'b0, B + 32'd0,  32'h0,         1'b1, 32'h0,         1'b0};
    vt[12] = '{1'b1, 1'b1, B + 32'd0,  32'h0000_BEEF, 1'b1, 32'hAAAA_0001, 1'b0};
    vt[13] = '{1'b1, 1'b0, B + 32'd0,  32'h0,         1'b1, 32'h0000_BEEF, 1'b0};

    // Reset held for two edges with random bus traffic on both instances.
    idle();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 2; s++) begin
        mem_wr[s] = 1'b1;
        mem_rd[s] = 1'($urandom_range(0, 1));
        addr[s]   = B + 32'(4 * $urandom_range(0, 2));
        wdata[s]  = $urandom;
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    idle();
    for (int s = 0; s < 2; s++) begin
      rd(s, B + 32'd0, 32'h0, 1'b0, "rst_th");
      rd(s, B + 32'd4, 32'h0, 1'b0, "rst_tl");
      rd(s, B + 32'd8, 32'h0, 1'b0, "rst_tcon");
    end

    // Reload and interrupt, PRESCALE=1.
    wr(0, B + 32'd0, 32'hFFFF_FFFD, 1'b0, "wr_th");
    wr(0, B + 32'd4, 32'hFFFF_FFFD, 1'b0, "wr_tl");
    wr(0, B + 32'd8, 32'd3,         1'b0, "wr_tcon3");
    rd(0, B + 32'd4, 32'hFFFF_FFFD, 1'b0, "tl_start");
    rd(0, B + 32'd4, 32'hFFFF_FFFE, 1'b0, "tl_fe");
    rd(0, B + 32'd4, 32'hFFFF_FFFF, 1'b0, "tl_ff");
    rd(0, B + 32'd4, 32'hFFFF_FFFD, 1'b1, "tl_reload");
    rd(0, B + 32'd8, 32'd7,         1'b1, "tcon_is");

    // Acknowledge, counting continues.
    wr(0, B + 32'd4, 32'd0, 1'b1, "wr_tl0");
    wr(0, B + 32'd8, 32'd3, 1'b1, "ack");
    rd(0, B + 32'd8, 32'd3, 1'b0, "tcon_acked");
    rd(0, B + 32'd4, 32'd2, 1'b0, "tl_counting");

    // TCON write on the overflow edge keeps IS.
    wr(0, B + 32'd4, 32'hFFFF_FFFF, 1'b0, "wr_tl_ff");
    wr(0, B + 32'd8, 32'd3,         1'b0, "tcon_on_ovf");
    rd(0, B + 32'd8, 32'd7,         1'b1, "tcon_kept_is");
    rd(0, B + 32'd4, 32'hFFFF_FFFE, 1'b1, "tl_after_ovf");

    // TCON=1 on an overflow edge: IS stays set, IE cleared masks Interrupt.
    wr(0, B + 32'd8, 32'd1,         1'b1, "tcon1_ovf");
    rd(0, B + 32'd8, 32'd5,         1'b0, "tcon_masked");
    rd(0, B + 32'd4, 32'hFFFF_FFFE, 1'b0, "tl_masked");

    // TH write on the overflow edge: reload uses the old TH.
    wr(0, B + 32'd0, 32'h0000_0010, 1'b0, "th_on_ovf");
    rd(0, B + 32'd4, 32'hFFFF_FFFD, 1'b0, "reload_old_th");
    rd(0, B + 32'd0, 32'h0000_0010, 1'b0, "th_new");

    // Table-driven decode and readback on the PRESCALE=4 instance.
    for (int i = 0; i < 14; i++) begin
      cycle(1, vt[i].r, vt[i].w, vt[i].a, vt[i].d, vt[i].chk, vt[i].er, vt[i].ei,
            $sformatf("vec%0d", i));
    end

    // Prescale by 4: TL steps every 4 edges after enable.
    wr(1, B + 32'd4, 32'd0, 1'b0, "ps_tl0");
    wr(1, B + 32'd8, 32'd1, 1'b0, "ps_en");
    for (int i = 0; i < 9; i++) begin
      rd(1, B + 32'd4, exp_tl[i], 1'b0, $sformatf("ps_tl%0d", i));
    end
    wr(1, B + 32'd8, 32'd0, 1'b0, "ps_stop");
    for (int i = 0; i < 3; i++) begin
      rd(1, B + 32'd4, 32'd2, 1'b0, $sformatf("ps_hold%0d", i));
    end
    wr(1, B + 32'd8, 32'd1, 1'b0, "ps_reen");
    for (int i = 0; i < 4; i++) begin
      rd(1, B + 32'd4, 32'd2, 1'b0, $sformatf("ps_wait%0d", i));
    end
    rd(1, B + 32'd4, 32'd3, 1'b0, "ps_step");

    // Reset while dut1 is counting.
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd(0, B + 32'd4, 32'h0, 1'b0, "mrst_tl");
    rd(0, B + 32'd8, 32'h0, 1'b0, "mrst_tcon");
    rd(0, B + 32'd0, 32'h0, 1'b0, "mrst_th");
    rd(0, B + 32'd4, 32'h0, 1'b0, "mrst_tl_held");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
